// File: rtl/mux_key_with_default_pkg.sv
// mux_key_with_default_pkg: shared width helper for the key/data pair layout
package mux_key_with_default_pkg;
  function automatic int pair_w(input int key_len, input int data_len);
    return key_len + data_len;
  endfunction
endpackage

// File: rtl/mux_key_internal.sv
// mux_key_internal: combinational pair match, lowest-index priority select, default fallback
module mux_key_internal
  import mux_key_with_default_pkg::*;
#(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  input  logic [KEY_LEN-1:0]                          key,
  input  logic [DATA_LEN-1:0]                         default_out,
  input  logic [NR_KEY*pair_w(KEY_LEN,DATA_LEN)-1:0]  lut,
  output logic [DATA_LEN-1:0]                         out,
  output logic                                        hit
);
  localparam int P = pair_w(KEY_LEN, DATA_LEN);
  // scanning from the top down lets the lowest matching index overwrite last
  always_comb begin
    out = default_out;
    hit = 1'b0;
    for (int i = NR_KEY - 1; i >= 0; i--)
      if (lut[P*i+DATA_LEN +: KEY_LEN] == key) begin
        out = lut[P*i +: DATA_LEN];
        hit = 1'b1;
      end
  end
endmodule

// File: rtl/mux_key_with_default.sv
// mux_key_with_default: key-indexed mux with default value and optional output register
module mux_key_with_default
  import mux_key_with_default_pkg::*;
#(
  parameter int                  NR_KEY    = 2,
  parameter int                  KEY_LEN   = 1,
  parameter int                  DATA_LEN  = 1,
  parameter bit                  REG_OUT   = 1'b0,
  parameter logic [DATA_LEN-1:0] RESET_VAL = '0
) (
  output logic [DATA_LEN-1:0]                         out,
  input  logic [KEY_LEN-1:0]                          key,
  input  logic [DATA_LEN-1:0]                         default_out,
  input  logic [NR_KEY*pair_w(KEY_LEN,DATA_LEN)-1:0]  lut,
  input  logic                                        clk,
  input  logic                                        rst_n,
  output logic                                        hit
);
  logic [DATA_LEN-1:0] w_out;
  logic                w_hit;
  if (NR_KEY < 1 || KEY_LEN < 1 || DATA_LEN < 1) begin : g_bad_params
    $error("mux_key_with_default: NR_KEY, KEY_LEN and DATA_LEN must all be >= 1");
  end
  mux_key_internal #(
    .NR_KEY  (NR_KEY),
    .KEY_LEN (KEY_LEN),
    .DATA_LEN(DATA_LEN)
  ) u_sel (
    .key        (key),
    .default_out(default_out),
    .lut        (lut),
    .out        (w_out),
    .hit        (w_hit)
  );
  if (REG_OUT) begin : g_reg
    logic [DATA_LEN-1:0] r_out;
    logic                r_hit;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        r_out <= RESET_VAL;
        r_hit <= 1'b0;
      end else begin
        r_out <= w_out;
        r_hit <= w_hit;
      end
    assign out = r_out;
    assign hit = r_hit;
  end else begin : g_comb
    // clock and reset are intentionally ignored in the combinational build
    logic w_unused;
    assign w_unused = clk ^ rst_n;
    assign out = w_out;
    assign hit = w_hit;
  end
endmodule

// File: tb/tb_mux_key_with_default.sv
// tb_mux_key_with_default: directed + randomized scoreboard check of comb and registered muxes
module tb_mux_key_with_default;
  typedef struct {
    logic [31:0] o;
    logic        h;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [0:0]  g_key;
  logic [31:0] g_def;
  logic [65:0] g_lut;
  logic [31:0] g_out;
  logic        g_hit;
  logic [1:0]  c_key;
  logic [7:0]  c_def;
  logic [29:0] c_lut;
  logic [7:0]  c_out, r_out;
  logic        c_hit, r_hit;

  mux_key_with_default #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(32), .REG_OUT(1'b0)) u_gpr (
    .out(g_out), .key(g_key), .default_out(g_def), .lut(g_lut), .clk(clk), .rst_n(rst_n), .hit(g_hit));
  mux_key_with_default #(.NR_KEY(3), .KEY_LEN(2), .DATA_LEN(8), .REG_OUT(1'b0)) u_comb (
    .out(c_out), .key(c_key), .default_out(c_def), .lut(c_lut), .clk(clk), .rst_n(rst_n), .hit(c_hit));
  mux_key_with_default #(.NR_KEY(3), .KEY_LEN(2), .DATA_LEN(8), .REG_OUT(1'b1), .RESET_VAL(8'h5A)) u_reg (
    .out(r_out), .key(c_key), .default_out(c_def), .lut(c_lut), .clk(clk), .rst_n(rst_n), .hit(r_hit));

  int n_cmp = 0;
  int n_bad = 0;
  bit sb_en = 1'b0;
  exp_t q_g[$], q_c[$], q_r[$];

  task automatic cmp(input string nm, input logic [31:0] ao, input logic ah,
                     input logic [31:0] eo, input logic eh);
    n_cmp++;
    if (ao !== eo || ah !== eh) begin
      n_bad++;
      $display("FAIL %s: got out=%h hit=%b, expected out=%h hit=%b", nm, ao, ah, eo, eh);
    end
  endtask

  // reference: first index whose key equals the probe wins, else default
  function automatic logic [32:0] ref_sel(input int n, input int k, input int ks[3],
                                          input logic [31:0] ds[3], input logic [31:0] d);
    for (int i = 0; i < n; i++)
      if (ks[i] == k) return {1'b1, ds[i]};
    return {1'b0, d};
  endfunction

  always @(negedge clk) if (sb_en) begin
    exp_t e;
    if (q_g.size() > 0) begin
      e = q_g.pop_front();
      cmp("rand_gpr", g_out, g_hit, e.o, e.h);
    end
    if (q_c.size() > 0) begin
      e = q_c.pop_front();
      cmp("rand_comb", {24'h0, c_out}, c_hit, e.o, e.h);
    end
    if (q_r.size() > 0 && q_r[0].due <= cyc) begin
      e = q_r.pop_front();
      if (e.due != cyc) cmp("rand_reg_stale", 32'(e.due), 1'b0, 32'(cyc), 1'b0);
      else cmp("rand_reg", {24'h0, r_out}, r_hit, e.o, e.h);
    end
  end

  initial begin
    int ks[3];
    logic [31:0] ds[3];
    logic [31:0] dflt;
    logic [32:0] r;
    exp_t e;
    g_lut = {1'b0, 32'h0, 1'b1, 32'hDEADBEEF};
    g_def = 32'h0;
    g_key = 1'b1;
    c_lut = {2'd2, 8'h33, 2'd1, 8'h22, 2'd0, 8'h11};
    c_def = 8'hEE;
    c_key = 2'd0;
    #1 rst_n = 1'b0;
    #1 cmp("reset_val", {24'h0, r_out}, r_hit, 32'h5A, 1'b0);
    cmp("gpr_key1", g_out, g_hit, 32'hDEADBEEF, 1'b1);
    g_key = 1'b0;
    #1 cmp("gpr_key0", g_out, g_hit, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      c_key = 2'(k);
      #1 cmp($sformatf("sweep_key%0d", k), {24'h0, c_out}, c_hit,
             (k == 3) ? 32'hEE : 32'h11 * (k + 1), k != 3);
    end
    c_lut = {2'd1, 8'hBB, 2'd2, 8'h33, 2'd1, 8'hAA};
    c_key = 2'd1;
    #1 cmp("dup_lowest", {24'h0, c_out}, c_hit, 32'hAA, 1'b1);
    c_lut = {2'd2, 8'h33, 2'd1, 8'h22, 2'd0, 8'h11};
    repeat (2) @(posedge clk);
    #1 cmp("reset_held", {24'h0, r_out}, r_hit, 32'h5A, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    c_key = 2'd2;
    #1 cmp("reg_not_before", {24'h0, r_out}, r_hit, 32'h5A, 1'b0);
    @(posedge clk);
    #1 cmp("reg_one_edge", {24'h0, r_out}, r_hit, 32'h33, 1'b1);
    #2 rst_n = 1'b0;
    #1 cmp("async_reset", {24'h0, r_out}, r_hit, 32'h5A, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 cmp("post_release_hold", {24'h0, r_out}, r_hit, 32'h5A, 1'b0);
    @(posedge clk);
    #1 cmp("recapture", {24'h0, r_out}, r_hit, 32'h33, 1'b1);
    sb_en = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        ks[i] = int'($urandom_range(0, 3));
        ds[i] = 32'($urandom_range(0, 255));
      end
      dflt = 32'($urandom_range(0, 255));
      c_key = 2'($urandom_range(0, 3));
      c_lut = {2'(ks[2]), ds[2][7:0], 2'(ks[1]), ds[1][7:0], 2'(ks[0]), ds[0][7:0]};
      c_def = dflt[7:0];
      r = ref_sel(3, int'(c_key), ks, ds, dflt);
      e.o = r[31:0];
      e.h = r[32];
      e.due = cyc;
      q_c.push_back(e);
      e.due = cyc + 1;
      q_r.push_back(e);
      for (int i = 0; i < 2; i++) begin
        ks[i] = int'($urandom_range(0, 1));
        ds[i] = $urandom;
      end
      dflt = $urandom;
      g_key = 1'($urandom_range(0, 1));
      g_lut = {1'(ks[1]), ds[1], 1'(ks[0]), ds[0]};
      g_def = dflt;
      r = ref_sel(2, int'(g_key), ks, ds, dflt);
      e.o = r[31:0];
      e.h = r[32];
      e.due = cyc;
      q_g.push_back(e);
    end
    repeat (2) @(posedge clk);
    #1 sb_en = 1'b0;
    cmp("drain", 32'(q_g.size() + q_c.size() + q_r.size()), 1'b0, 32'h0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
